// File: rtl/imem_dual_region.sv
// Dual-region (user/kernel) instruction memory with a registered 1-cycle fetch port.
// The load session (RUN/LOAD/FLUSH) is compiled in only when IMEM_LOAD_EN is defined.
module imem_dual_region #(
  parameter int USER_DEPTH   = 256,
  parameter int KERNEL_DEPTH = 32,
  parameter int IDX_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_addr,
  input  logic             stall,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             addr_fault,
  input  logic             load_en,
  input  logic             load_we,
  input  logic             load_kernel,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [31:0]      load_data,
  output logic             load_busy,
  output logic [15:0]      load_count
);

  localparam int UA_W = (USER_DEPTH > 1) ? $clog2(USER_DEPTH) : 1;
  localparam int KA_W = (KERNEL_DEPTH > 1) ? $clog2(KERNEL_DEPTH) : 1;
  localparam logic [IDX_W:0] U_LIM = (IDX_W+1)'(USER_DEPTH);
  localparam logic [IDX_W:0] K_LIM = (IDX_W+1)'(KERNEL_DEPTH);

  typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_t;
  typedef logic [31:0] umem_t [USER_DEPTH];
  typedef logic [31:0] kmem_t [KERNEL_DEPTH];

  // Build-time program image: small user program, boot handler in kernel space.
  function automatic umem_t user_image();
    umem_t m;
    for (int i = 0; i < USER_DEPTH; i++) begin
      case (i)
        0:       m[i] = 32'h00000013;
        1:       m[i] = 32'h00100093;
        2:       m[i] = 32'h00200113;
        3:       m[i] = 32'h002081B3;
        4:       m[i] = 32'h0000006F;
        default: m[i] = 32'h00000000;
      endcase
    end
    return m;
  endfunction

  function automatic kmem_t kernel_image();
    kmem_t m;
    for (int i = 0; i < KERNEL_DEPTH; i++) begin
      case (i)
        0:       m[i] = 32'h34202573;
        1:       m[i] = 32'h00000013;
        2:       m[i] = 32'h30200073;
        3:       m[i] = 32'h0000006F;
        default: m[i] = 32'h00000000;
      endcase
    end
    return m;
  endfunction

  umem_t umem = user_image();
  kmem_t kmem = kernel_image();

  state_t state, state_n;
  logic   wr;

  // Fetch decode: misaligned or past the end of the selected region is a fault.
  logic [IDX_W-1:0] f_idx;
  logic             f_kern, f_bad;
  logic [31:0]      f_word;

  assign f_idx  = fetch_addr[IDX_W+1:2];
  assign f_kern = fetch_addr[31];
  assign f_bad  = (fetch_addr[1:0] != 2'b00) ||
                  (f_kern ? ({1'b0, f_idx} >= K_LIM) : ({1'b0, f_idx} >= U_LIM));

  always_comb begin
    f_word = '0;
    if (!f_bad) f_word = f_kern ? kmem[f_idx[KA_W-1:0]] : umem[f_idx[UA_W-1:0]];
  end

  logic unused_addr;
  assign unused_addr = ^fetch_addr[30:IDX_W+2];

`ifdef IMEM_LOAD_EN
  logic l_ok;
  assign l_ok = load_kernel ? ({1'b0, load_idx} < K_LIM) : ({1'b0, load_idx} < U_LIM);
  assign wr   = (state == LOAD) && load_we && l_ok && !reset;

  always_ff @(posedge clk) begin
    if (wr) begin
      if (load_kernel) kmem[load_idx[KA_W-1:0]] <= load_data;
      else             umem[load_idx[UA_W-1:0]] <= load_data;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (load_en) state_n = LOAD;
      LOAD:    if (!load_en) state_n = FLUSH;
      FLUSH:   state_n = RUN;
      default: state_n = RUN;
    endcase
  end
`else
  assign wr      = 1'b0;
  assign state_n = RUN;

  logic unused_load;
  assign unused_load = ^{load_en, load_we, load_kernel, load_idx, load_data};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
      load_count  <= '0;
    end else begin
      state <= state_n;
      // Anything other than RUN->RUN blanks the fetch port; this also lets a load beat stall.
      if (state != RUN || state_n != RUN) begin
        instr       <= '0;
        instr_valid <= 1'b0;
        addr_fault  <= 1'b0;
      end else if (!stall) begin
        if (fetch_req) begin
          instr       <= f_word;
          instr_valid <= 1'b1;
          addr_fault  <= f_bad;
        end else begin
          instr_valid <= 1'b0;
          addr_fault  <= 1'b0;
        end
      end
      if (state == RUN && state_n == LOAD) load_count <= '0;
      else if (wr && load_count != 16'hFFFF) load_count <= load_count + 16'd1;
    end
  end

  assign load_busy = (state != RUN);

endmodule

// File: tb/tb_imem_dual_region.sv
// Scoreboard bench for imem_dual_region: directed cases then random traffic,
// checked against a per-cycle behavioural model of the memory and load session.
module tb_imem_dual_region;
  localparam int UD = 256;
  localparam int KD = 32;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          reset, fetch_req, stall, load_en, load_we, load_kernel;
  logic [31:0]   fetch_addr, load_data;
  logic [IW-1:0] load_idx;
  logic [31:0]   instr;
  logic          instr_valid, addr_fault, load_busy;
  logic [15:0]   load_count;

  always #5 clk = ~clk;

  imem_dual_region #(.USER_DEPTH(UD), .KERNEL_DEPTH(KD), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .addr_fault(addr_fault),
    .load_en(load_en), .load_we(load_we), .load_kernel(load_kernel), .load_idx(load_idx),
    .load_data(load_data), .load_busy(load_busy), .load_count(load_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  logic [31:0] um [UD];
  logic [31:0] km [KD];
  int          mode;   // 0 = running, 1 = loading, 2 = flushing
  logic [31:0] m_instr;
  logic        m_valid, m_fault;
  int          m_cnt;

  function automatic logic [31:0] user_img(int i);
    case (i)
      0: return 32'h00000013;
      1: return 32'h00100093;
      2: return 32'h00200113;
      3: return 32'h002081B3;
      4: return 32'h0000006F;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] kern_img(int i);
    case (i)
      0: return 32'h34202573;
      1: return 32'h00000013;
      2: return 32'h30200073;
      3: return 32'h0000006F;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
    end
  endfunction

  // One clock of the specified behaviour, from the inputs currently applied.
  task automatic model();
    int nmode, idx, dep;
    bit bad;
    if (reset) begin
      mode = 0; m_instr = 0; m_valid = 0; m_fault = 0; m_cnt = 0;
      return;
    end
`ifdef IMEM_LOAD_EN
    nmode = mode;
    if (mode == 0 && load_en) nmode = 1;
    else if (mode == 1 && !load_en) nmode = 2;
    else if (mode == 2) nmode = 0;
`else
    nmode = 0;
`endif
    if (mode != 0 || nmode != 0) begin
      m_instr = 0; m_valid = 0; m_fault = 0;
    end else if (!stall) begin
      if (fetch_req) begin
        idx = int'((fetch_addr >> 2) & ((32'd1 << IW) - 1));
        dep = fetch_addr[31] ? KD : UD;
        bad = (fetch_addr % 4 != 0) || (idx >= dep);
        m_instr = 0;
        if (!bad) m_instr = fetch_addr[31] ? km[idx] : um[idx];
        m_valid = 1;
        m_fault = bad;
      end else begin
        m_valid = 0; m_fault = 0;
      end
    end
    if (mode == 1 && load_we) begin
      dep = load_kernel ? KD : UD;
      if (int'(load_idx) < dep) begin
        if (load_kernel) km[int'(load_idx)] = load_data;
        else             um[int'(load_idx)] = load_data;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    if (mode == 0 && nmode == 1) m_cnt = 0;
    mode = nmode;
  endtask

  task automatic step();
    exp_t e;
    model();
    @(posedge clk);
    e.instr = m_instr; e.valid = m_valid; e.fault = m_fault;
    e.busy  = (mode != 0); e.cnt = 16'(m_cnt);
    q.push_back(e);
    #1;
  endtask

  task automatic idle();
    reset = 0; fetch_req = 0; fetch_addr = 0; stall = 0;
    load_en = 0; load_we = 0; load_kernel = 0; load_idx = '0; load_data = 0;
  endtask

  // Monitor: every cycle after an edge the DUT presents its registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("instr", instr, e.instr);
        chk("instr_valid", 32'(instr_valid), 32'(e.valid));
        if (e.valid) chk("addr_fault", 32'(addr_fault), 32'(e.fault));
        chk("load_busy", 32'(load_busy), 32'(e.busy));
        chk("load_count", 32'(load_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    int in_sess;
    for (int i = 0; i < UD; i++) um[i] = user_img(i);
    for (int i = 0; i < KD; i++) km[i] = kern_img(i);
    mode = 0; m_instr = 0; m_valid = 0; m_fault = 0; m_cnt = 0;

    idle();
    reset = 1; step(); step();
    reset = 0;
    fetch_req = 1;
    fetch_addr = 32'h00000000; step();
    fetch_addr = 32'h80000008; step();
    fetch_addr = 32'h80000080; step();
    fetch_addr = 32'h8000007C; step();
    fetch_addr = 32'h00000400; step();
    fetch_addr = 32'h000003FC; step();
    fetch_addr = 32'h00000002; step();
    fetch_addr = 32'h00000004; step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      fetch_req = ~fetch_req; fetch_addr = 32'h00000008; step();
    end
    stall = 0; fetch_req = 0; step();

`ifdef IMEM_LOAD_EN
    fetch_req = 1; fetch_addr = 32'h0; load_en = 1; step();
    fetch_req = 0; load_we = 1; load_kernel = 0;
    load_idx = 9'd5;   load_data = 32'hDEADBEEF; step();
    load_idx = 9'd300; load_data = 32'h12345678; step();
    load_kernel = 1; load_idx = 9'd40; load_data = 32'hCAFEF00D; step();
    load_we = 0; load_en = 0; step();
    step();
    fetch_req = 1; fetch_addr = 32'h00000014; step();
    fetch_addr = 32'h000004B0; step();
    fetch_req = 0; step();

    load_en = 1; step();
    load_we = 1; load_kernel = 0; load_idx = 9'd7; load_data = 32'hA5A5A5A5; step();
    load_kernel = 1; load_idx = 9'd3; load_data = 32'h5A5A5A5A; step();
    load_we = 0; reset = 1; step();
    reset = 0; load_en = 0; fetch_req = 1;
    fetch_addr = 32'h0000001C; step();
    fetch_addr = 32'h8000000C; step();
    fetch_req = 0; step();
`endif

    in_sess = 0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      fetch_req = $urandom_range(0, 1);
      stall = ($urandom_range(0, 4) == 0);
      fetch_addr = ({31'd0, 1'($urandom_range(0, 1))} << 31)
                 | (32'($urandom_range(0, 300)) << 2)
                 | (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      if (!in_sess && $urandom_range(0, 19) == 0) in_sess = 1;
      else if (in_sess && $urandom_range(0, 4) == 0) in_sess = 0;
      load_en = in_sess[0];
      load_we = $urandom_range(0, 1);
      load_kernel = $urandom_range(0, 1);
      load_idx = IW'($urandom_range(0, 300));
      load_data = $urandom;
      step();
    end

    idle();
    step(); step();
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
